// File: rtl/fetch_stage_pkg.sv
// Shared core constants: bubble encoding, default boot address, RV32I
// major opcodes, and a word-alignment helper. Imported by fetch, decode,
// immediate_generator and the control decoder.
package fetch_stage_pkg;

   // addi x0,x0,0 -- the canonical bubble
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   // BIOS base
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

   // RV32I major opcodes (inst[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Clear the low two bits; misaligned targets are aligned silently.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Holds the fetch PC, drives a 1-cycle-latency synchronous instruction
// memory, and presents inst/pc/inst_valid to decode. Stalls freeze fetch
// and hold decode-facing outputs; redirects restart fetch with one bubble.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   stall             hazard unit freeze
//   redirect          taken branch/jump; restart at redirect_pc
//   redirect_pc[31:0] target byte address (bits [1:0] forced to 0)
//   imem_en           memory read enable
//   imem_addr[31:0]   memory byte address (word aligned)
//   imem_dout[31:0]   read data for the previous cycle's address
//   inst[31:0]        instruction to decode
//   pc[31:0]          PC of inst
//   inst_valid        inst is real, not a bubble
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP      = NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_dout,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_valid
);

   // BUBBLE: nothing valid returning. RUN: memory data is live.
   // HOLD: memory data was captured on the first stalled cycle.
   typedef enum logic [1:0] {
      BUBBLE = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic [31:0] pc_d, pc_d_n;
   logic [31:0] hold_inst, hold_inst_n;

   // Next-state and register updates; redirect outranks stall.
   always_comb begin
      state_n     = state;
      fetch_pc_n  = fetch_pc;
      pc_d_n      = pc_d;
      hold_inst_n = hold_inst;
      if (redirect) begin
         fetch_pc_n = word_align(redirect_pc);
         pc_d_n     = word_align(redirect_pc);
         state_n    = BUBBLE;
      end else if (stall) begin
         // Memory keeps re-reading fetch_pc, but the word in decode must
         // survive, so capture it once on entry to the stall.
         if (state == RUN) begin
            state_n     = HOLD;
            hold_inst_n = imem_dout;
         end
      end else begin
         fetch_pc_n = fetch_pc + 32'd4;
         pc_d_n     = fetch_pc;
         state_n    = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BUBBLE;
         fetch_pc  <= RESET_PC;
         pc_d      <= RESET_PC;
         hold_inst <= NOP;
      end else begin
         state     <= state_n;
         fetch_pc  <= fetch_pc_n;
         pc_d      <= pc_d_n;
         hold_inst <= hold_inst_n;
      end
   end

   // Reset overrides outputs combinationally so the reset cycle itself
   // shows reset values even when it interrupts a stall or redirect.
   always_comb begin
      imem_en    = !rst;
      imem_addr  = rst ? RESET_PC : fetch_pc;
      pc         = rst ? RESET_PC : pc_d;
      inst       = NOP;
      inst_valid = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               inst       = imem_dout;
               inst_valid = 1'b1;
            end
            HOLD: begin
               inst       = hold_inst;
               inst_valid = 1'b1;
            end
            default: begin
               inst       = NOP;
               inst_valid = 1'b0;
            end
         endcase
      end
   end

endmodule
